// File: rtl/stock_feed_packer_if.sv
// Handshake and output bundle between the price source/evaluator side and stock_feed_packer.
// The master modport belongs to the side that offers prices and action codes.
interface stock_feed_packer_if #(
  parameter int RAW_W = 8
);
  logic             price_valid;
  logic [RAW_W-1:0] price_in;
  logic             price_ready;
  logic [15:0]      action_in;
  logic [15:0]      stock_out;
  logic             frame_valid;
  logic             frame_start;
  logic             action_err;

  modport master (
    output price_valid, price_in, action_in,
    input  price_ready, stock_out, frame_valid, frame_start, action_err
  );

  modport slave (
    input  price_valid, price_in, action_in,
    output price_ready, stock_out, frame_valid, frame_start, action_err
  );
endinterface

// File: rtl/stock_feed_packer.sv
// Buffers saturated daily prices, keeps a 3-day sliding window and emits
// {owned, day1, day2, day3} once per evaluator frame, tracking ownership from action codes.
module stock_feed_packer #(
  parameter int RAW_W        = 8,
  parameter int FIFO_DEPTH   = 4,
  parameter int FRAME_CYCLES = 6
) (
  input logic                clk,
  input logic                rst,
  stock_feed_packer_if.slave bus
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = $clog2(FRAME_CYCLES);

  typedef enum logic {FILL, RUN} state_e;

  // Frame phase and FIFO state
  logic [CNT_W-1:0] frame_cnt_q, frame_cnt_d;
  logic [PTR_W:0]   wr_ptr_q, rd_ptr_q;
  logic [4:0]       mem_q [FIFO_DEPTH];

  // Window, FSM and registered outputs
  state_e     state_q, state_d;
  logic [1:0] win_cnt_q, win_cnt_d;
  logic [4:0] day1_q, day2_q, day3_q;
  logic [4:0] day1_d, day2_d, day3_d;
  logic [15:0] stock_q, stock_d;
  logic       frame_valid_q, frame_valid_d;
  logic       owned_q, owned_d;
  logic       err_q, err_d;

  logic       boundary, full, empty, push, pop, load;
  logic [4:0] sat_price;

  assign boundary = (frame_cnt_q == CNT_W'(FRAME_CYCLES - 1));
  assign empty    = (wr_ptr_q == rd_ptr_q);
  // Extra pointer bit distinguishes full from empty when the index bits match.
  assign full     = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                    (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
  assign push     = bus.price_valid && !full;
  assign pop      = boundary && !empty;

  assign sat_price   = (bus.price_in > RAW_W'(31)) ? 5'd31 : bus.price_in[4:0];
  assign frame_cnt_d = boundary ? '0 : frame_cnt_q + CNT_W'(1);

  // NOTE: every variable assigned here gets a default first so no latch is inferred.
  always_comb begin
    day1_d        = day1_q;
    day2_d        = day2_q;
    day3_d        = day3_q;
    win_cnt_d     = win_cnt_q;
    state_d       = state_q;
    stock_d       = stock_q;
    frame_valid_d = frame_valid_q;
    owned_d       = owned_q;
    err_d         = err_q;
    load          = 1'b0;

    if (pop) begin
      day1_d = day2_q;
      day2_d = day3_q;
      day3_d = mem_q[rd_ptr_q[PTR_W-1:0]];
      unique case (state_q)
        FILL: begin
          win_cnt_d = win_cnt_q + 2'd1;
          if (win_cnt_d == 2'd3) state_d = RUN;
        end
        RUN:  win_cnt_d = 2'd3;
        default: state_d = FILL;
      endcase
    end

    // An empty FIFO in RUN still reloads, so fresh ownership reaches bit 15.
    load = boundary && (win_cnt_d == 2'd3);
    if (load) begin
      stock_d       = {owned_q, day1_d, day2_d, day3_d};
      frame_valid_d = 1'b1;
    end

    // The evaluator presents its action code only while in IDLE.
    if (frame_cnt_q == '0) begin
      case (bus.action_in)
        16'd3, 16'd4, 16'd6, 16'd7: owned_d = 1'b1;
        16'd1:                      owned_d = 1'b0;
        16'd0, 16'd2, 16'd5, 16'd8: owned_d = owned_q;
        default:                    err_d   = 1'b1;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frame_cnt_q   <= '0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      state_q       <= FILL;
      win_cnt_q     <= 2'd0;
      day1_q        <= 5'd0;
      day2_q        <= 5'd0;
      day3_q        <= 5'd0;
      stock_q       <= 16'd0;
      frame_valid_q <= 1'b0;
      owned_q       <= 1'b0;
      err_q         <= 1'b0;
    end else begin
      frame_cnt_q   <= frame_cnt_d;
      if (push) wr_ptr_q <= wr_ptr_q + (PTR_W+1)'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + (PTR_W+1)'(1);
      state_q       <= state_d;
      win_cnt_q     <= win_cnt_d;
      day1_q        <= day1_d;
      day2_q        <= day2_d;
      day3_q        <= day3_d;
      stock_q       <= stock_d;
      frame_valid_q <= frame_valid_d;
      owned_q       <= owned_d;
      err_q         <= err_d;
    end
  end

  // NOTE: FIFO storage has no reset; the pointers alone define which entries are valid.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q[PTR_W-1:0]] <= sat_price;
  end

  assign bus.price_ready = !full;
  assign bus.stock_out   = stock_q;
  assign bus.frame_valid = frame_valid_q;
  assign bus.frame_start = (frame_cnt_q == '0);
  assign bus.action_err  = err_q;
endmodule

// File: tb/tb_stock_feed_packer.sv
// Directed plus randomized bench for stock_feed_packer, compared every cycle against
// a queue-based model of the FIFO, sliding window and ownership rules.
module tb_stock_feed_packer;
  logic clk = 1'b0;
  logic rst = 1'b1;

  stock_feed_packer_if #(.RAW_W(8)) bus ();

  stock_feed_packer #(.RAW_W(8), .FIFO_DEPTH(4), .FRAME_CYCLES(6)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model state
  int        m_cnt;
  bit [4:0]  m_fifo[$];
  bit [4:0]  m_win[$];
  bit        m_owned, m_fv, m_err;
  bit [15:0] m_stock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask

  task automatic model_reset();
    m_cnt = 0;
    m_fifo.delete();
    m_win.delete();
    m_owned = 1'b0;
    m_fv    = 1'b0;
    m_err   = 1'b0;
    m_stock = 16'd0;
  endtask

  task automatic model_step(input bit v, input bit [7:0] p, input bit [15:0] a);
    bit ready;
    ready = (m_fifo.size() < 4);
    if (m_cnt == 5 && m_fifo.size() > 0) begin
      m_win.push_back(m_fifo.pop_front());
      if (m_win.size() > 3) void'(m_win.pop_front());
    end
    if (m_cnt == 5 && m_win.size() == 3) begin
      m_stock = {m_owned, m_win[0], m_win[1], m_win[2]};
      m_fv    = 1'b1;
    end
    if (v && ready) m_fifo.push_back((p > 8'd31) ? 5'd31 : p[4:0]);
    if (m_cnt == 0) begin
      if (a inside {16'd3, 16'd4, 16'd6, 16'd7}) m_owned = 1'b1;
      else if (a == 16'd1)                       m_owned = 1'b0;
      else if (a > 16'd8)                        m_err   = 1'b1;
    end
    m_cnt = (m_cnt + 1) % 6;
  endtask

  task automatic compare_all();
    check("stock_out",   bus.stock_out,   m_stock);
    check("frame_valid", bus.frame_valid, m_fv);
    check("frame_start", bus.frame_start, (m_cnt == 0));
    check("action_err",  bus.action_err,  m_err);
    check("price_ready", bus.price_ready, (m_fifo.size() < 4));
  endtask

  // Called just after a falling edge: drive, advance model, then sample at the next falling edge.
  task automatic cycle(input bit v, input bit [7:0] p, input bit [15:0] a);
    bus.price_valid = v;
    bus.price_in    = p;
    bus.action_in   = a;
    model_step(v, p, a);
    @(posedge clk);
    @(negedge clk);
    #1;
    compare_all();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 8'd0, 16'd0);
  endtask

  task automatic do_reset();
    bus.price_valid = 1'b0;
    bus.price_in    = '0;
    bus.action_in   = '0;
    rst = 1'b1;
    #1;
    check("rst_stock",  bus.stock_out,   16'd0);
    check("rst_fvalid", bus.frame_valid, 1'b0);
    check("rst_err",    bus.action_err,  1'b0);
    check("rst_ready",  bus.price_ready, 1'b1);
    model_reset();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("post_rst_fstart", bus.frame_start, 1'b1);
    compare_all();
  endtask

  initial begin
    bit        v;
    bit [7:0]  p;
    bit [15:0] a;

    bus.price_valid = 1'b0;
    bus.price_in    = '0;
    bus.action_in   = '0;
    model_reset();
    @(negedge clk);
    do_reset();

    // Fill the window with 10,20,30; first load happens at the third boundary.
    cycle(1'b1, 8'd10, 16'd0);
    cycle(1'b1, 8'd20, 16'd0);
    cycle(1'b1, 8'd30, 16'd0);
    idle(14);
    check("pre_first_load", bus.stock_out, 16'd0);
    idle(1);
    check("first_load", bus.stock_out, 16'h2A9E);
    check("first_fvalid", bus.frame_valid, 1'b1);

    // Saturation of 40 and 200.
    cycle(1'b1, 8'd40, 16'd0);
    cycle(1'b1, 8'd200, 16'd0);
    idle(10);
    check("saturated_win", bus.stock_out, {1'b0, 5'd30, 5'd31, 5'd31});

    // FIFO fills in four cycles, rejects while full, frees one slot after the boundary.
    for (int i = 0; i < 4; i++) cycle(1'b1, 8'(i + 1), 16'd0);
    check("full_not_ready", bus.price_ready, 1'b0);
    cycle(1'b1, 8'd99, 16'd0);
    cycle(1'b1, 8'd98, 16'd0);
    check("ready_after_pop", bus.price_ready, 1'b1);
    idle(24);

    // Ownership codes.
    cycle(1'b0, 8'd0, 16'd4);
    idle(5);
    check("owned_buy", bus.stock_out[15], 1'b1);
    cycle(1'b0, 8'd0, 16'd1);
    idle(5);
    check("owned_sell", bus.stock_out[15], 1'b0);
    cycle(1'b0, 8'd0, 16'd5);
    idle(5);
    check("owned_hold", bus.stock_out[15], 1'b0);
    cycle(1'b0, 8'd0, 16'd4);
    idle(5);
    cycle(1'b0, 8'd0, 16'd9);
    idle(5);
    check("err_set", bus.action_err, 1'b1);
    check("owned_after_err", bus.stock_out[15], 1'b1);
    cycle(1'b0, 8'd0, 16'd0);
    cycle(1'b0, 8'd0, 16'd1);
    idle(4);
    check("off_phase_ignored", bus.stock_out[15], 1'b1);
    check("err_sticky", bus.action_err, 1'b1);

    // Reset mid-frame with two prices queued.
    cycle(1'b1, 8'd7, 16'd0);
    cycle(1'b1, 8'd9, 16'd0);
    cycle(1'b0, 8'd0, 16'd0);
    do_reset();

    // Randomized traffic, with one extra reset in the middle.
    for (int i = 0; i < 3000; i++) begin
      if (i == 1500) do_reset();
      v = ($urandom_range(0, 2) != 0);
      p = 8'($urandom_range(0, 255));
      a = ($urandom_range(0, 5) == 0) ? 16'($urandom_range(0, 12)) : 16'd0;
      cycle(v, p, a);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
